// File: rtl/pss_gen_pkg.sv
// Shared constants, FSM state type and helpers for the PSS generator.
// Optional macro PSS_GENERATOR_GUARD_EN adds the SSB guard-band states.
package pss_gen_pkg;

  localparam int PSS_LEN    = 127;
  localparam int PSS_SHIFT  = 43;
  localparam logic [6:0] LFSR_INIT = 7'b1110110;  // x6..x0
  localparam int SSB_SC     = 240;
  localparam int GUARD_PRE  = 56;
  localparam int GUARD_POST = 57;

`ifdef PSS_GENERATOR_GUARD_EN
  typedef enum logic [2:0] {IDLE, PRERUN, GUARD_A, EMIT, GUARD_B} state_e;
`else
  typedef enum logic [2:0] {IDLE, PRERUN, EMIT} state_e;
`endif

  // Number of LFSR pre-steps that realise the cyclic shift 43*N_id_2.
  function automatic logic [6:0] prerun_len(input logic [1:0] nid);
    return 7'(PSS_SHIFT) * {5'd0, nid};
  endfunction

endpackage

// File: rtl/pss_lfsr.sv
// 7-bit m-sequence generator for x(i+7) = x(i+4) ^ x(i); output is x(i).
module pss_lfsr
  import pss_gen_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic step,
  output logic x_bit
);

  logic [6:0] s_q;

  // Load restarts the sequence at x(0) and wins over step.
  always_ff @(posedge clk) begin
    // NOTE: registers use non-blocking assignments so every flop updates from pre-edge values.
    if (!rst_n) begin
      s_q <= LFSR_INIT;
    end else if (load) begin
      s_q <= LFSR_INIT;
    end else if (step) begin
      s_q <= {s_q[4] ^ s_q[0], s_q[6:1]};
    end
  end

  assign x_bit = s_q[0];

endmodule

// File: rtl/pss_generator.sv
// NR PSS BPSK sequence source on an AXI-stream master with backpressure.
// Optional macro PSS_GENERATOR_GUARD_EN frames the output as a 240-subcarrier
// SSB symbol with zero guard samples around the 127 PSS samples.
module pss_generator
  import pss_gen_pkg::*;
#(
  parameter int OUT_DW = 32,
  parameter int AMP    = 8191
) (
  input  logic              clk_i,
  input  logic              reset_ni,
  input  logic              start_i,
  input  logic [1:0]        N_id_2_i,
  output logic [OUT_DW-1:0] m_axis_out_tdata,
  output logic              m_axis_out_tvalid,
  input  logic              m_axis_out_tready,
  output logic              m_axis_out_tlast,
  output logic              busy_o
);

  localparam int HALF = OUT_DW / 2;
  localparam logic signed [HALF-1:0] AMP_POS = HALF'(AMP);
  localparam logic signed [HALF-1:0] AMP_NEG = -AMP_POS;

`ifdef PSS_GENERATOR_GUARD_EN
  localparam state_e     FIRST_EMIT = GUARD_A;
  localparam logic [7:0] PSS_FIRST  = 8'(GUARD_PRE);
  localparam logic [7:0] PSS_END    = 8'(GUARD_PRE + PSS_LEN - 1);
  localparam logic [7:0] LAST_IDX   = 8'(GUARD_PRE + PSS_LEN + GUARD_POST - 1);
`else
  localparam state_e     FIRST_EMIT = EMIT;
  localparam logic [7:0] LAST_IDX   = 8'(PSS_LEN - 1);
`endif

  state_e                 state_q, state_d;
  logic [6:0]             prerun_q, prerun_d;
  logic [7:0]             sample_q, sample_d;
  logic                   lfsr_load, lfsr_step, x_bit;
  logic                   pss_sample;
  logic signed [HALF-1:0] re_val;

  pss_lfsr u_lfsr (
    .clk   (clk_i),
    .rst_n (reset_ni),
    .load  (lfsr_load),
    .step  (lfsr_step),
    .x_bit (x_bit)
  );

  // State, pre-run countdown and sample index registers.
  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      state_q  <= IDLE;
      prerun_q <= '0;
      sample_q <= '0;
    end else begin
      state_q  <= state_d;
      prerun_q <= prerun_d;
      sample_q <= sample_d;
    end
  end

  // Next-state, LFSR control and stream outputs.
  always_comb begin
    // NOTE: every signal written here gets a default first so no path infers a latch.
    state_d           = state_q;
    prerun_d          = prerun_q;
    sample_d          = sample_q;
    lfsr_load         = 1'b0;
    lfsr_step         = 1'b0;
    pss_sample        = 1'b0;
    m_axis_out_tvalid = 1'b0;
    m_axis_out_tlast  = 1'b0;

    case (state_q)
      IDLE: begin
        sample_d = '0;
        if (start_i && (N_id_2_i != 2'd3)) begin
          lfsr_load = 1'b1;
          prerun_d  = prerun_len(N_id_2_i);
          state_d   = (N_id_2_i == 2'd0) ? FIRST_EMIT : PRERUN;
        end
      end

      PRERUN: begin
        lfsr_step = 1'b1;
        prerun_d  = prerun_q - 7'd1;
        if (prerun_q == 7'd1) state_d = FIRST_EMIT;
      end

`ifdef PSS_GENERATOR_GUARD_EN
      GUARD_A: begin
        m_axis_out_tvalid = 1'b1;
        if (m_axis_out_tready) begin
          sample_d = sample_q + 8'd1;
          if (sample_q == PSS_FIRST - 8'd1) state_d = EMIT;
        end
      end

      EMIT: begin
        m_axis_out_tvalid = 1'b1;
        pss_sample        = 1'b1;
        if (m_axis_out_tready) begin
          lfsr_step = 1'b1;
          sample_d  = sample_q + 8'd1;
          if (sample_q == PSS_END) state_d = GUARD_B;
        end
      end

      GUARD_B: begin
        m_axis_out_tvalid = 1'b1;
        m_axis_out_tlast  = (sample_q == LAST_IDX);
        if (m_axis_out_tready) begin
          sample_d = sample_q + 8'd1;
          if (sample_q == LAST_IDX) begin
            sample_d = '0;
            state_d  = IDLE;
          end
        end
      end
`else
      EMIT: begin
        m_axis_out_tvalid = 1'b1;
        pss_sample        = 1'b1;
        m_axis_out_tlast  = (sample_q == LAST_IDX);
        if (m_axis_out_tready) begin
          lfsr_step = 1'b1;
          sample_d  = sample_q + 8'd1;
          if (sample_q == LAST_IDX) begin
            sample_d = '0;
            state_d  = IDLE;
          end
        end
      end
`endif

      default: state_d = IDLE;
    endcase
  end

  // BPSK mapping: x=0 -> +AMP, x=1 -> -AMP; imag is always zero, guards are zero.
  always_comb begin
    re_val           = x_bit ? AMP_NEG : AMP_POS;
    m_axis_out_tdata = '0;
    if (pss_sample) m_axis_out_tdata = {{HALF{1'b0}}, re_val};
  end

  assign busy_o = (state_q != IDLE);

endmodule
